// File: rtl/rob_pkg.sv
// Shared types and default widths for the reorder buffer.
// The entry record uses the default register-file widths below.
package rob_pkg;

    localparam int unsigned ROB_ARCH_REGS = 32;
    localparam int unsigned ROB_PHYS_REGS = 64;
    localparam int unsigned ROB_AW        = $clog2(ROB_ARCH_REGS);
    localparam int unsigned ROB_PW        = $clog2(ROB_PHYS_REGS);

    typedef enum logic {
        FlushMispred = 1'b0,
        FlushExc     = 1'b1
    } flush_cause_e;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              mispred;
        logic              exc;
        logic              rd_wen;
        logic [ROB_AW-1:0] rd_arch;
        logic [ROB_PW-1:0] t;
        logic [ROB_PW-1:0] t_old;
    } rob_entry_t;

endpackage

// File: rtl/rob_commit_select.sv
// Scans the head window and picks the retiring lanes plus any flush request.
// Exception-triggered flushes exist only when ROB_EXCEPTION_EN is defined.
module rob_commit_select
    import rob_pkg::*;
#(
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned LW           = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
    input  rob_entry_t [COMMIT_WIDTH-1:0] win_i,
    output logic [COMMIT_WIDTH-1:0]       commit_valid_o,
    output logic                          flush_o,
    output logic                          flush_cause_o,
    output logic [LW-1:0]                 flush_lane_o
);

    logic blocked;
    logic exc_k;

    always_comb begin
        commit_valid_o = '0;
        flush_o        = 1'b0;
        flush_cause_o  = FlushMispred;
        flush_lane_o   = '0;
        blocked        = 1'b0;
        exc_k          = 1'b0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
`ifdef ROB_EXCEPTION_EN
            exc_k = win_i[k].exc;
`else
            exc_k = 1'b0;
`endif
            if (!blocked) begin
                if (win_i[k].valid && win_i[k].done && !exc_k) begin
                    commit_valid_o[k] = 1'b1;
                    // A mispredicted branch retires but younger lanes are squashed.
                    if (win_i[k].mispred) begin
                        flush_o      = 1'b1;
                        flush_lane_o = LW'(k);
                        blocked      = 1'b1;
                    end
                end else begin
                    blocked = 1'b1;
                    if (k == 0 && win_i[k].valid && win_i[k].done && exc_k) begin
                        flush_o       = 1'b1;
                        flush_cause_o = FlushExc;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: multi-lane dispatch, writeback marking, in-order commit, flush.
// Optional macro ROB_EXCEPTION_EN enables exception tracking and exception flushes.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH          = 32,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned WB_WIDTH       = 4,
    parameter int unsigned ARCH_REGS      = ROB_ARCH_REGS,
    parameter int unsigned PHYS_REGS      = ROB_PHYS_REGS,
    localparam int unsigned AW            = $clog2(ARCH_REGS),
    localparam int unsigned PW            = $clog2(PHYS_REGS),
    localparam int unsigned IW            = $clog2(DEPTH)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DISPATCH_WIDTH-1:0]           disp_valid_i,
    input  logic [DISPATCH_WIDTH-1:0]           disp_rd_wen_i,
    input  logic [DISPATCH_WIDTH-1:0][AW-1:0]   disp_rd_arch_i,
    input  logic [DISPATCH_WIDTH-1:0][PW-1:0]   disp_new_prf_i,
    input  logic [DISPATCH_WIDTH-1:0][PW-1:0]   disp_old_prf_i,
    output logic [DISPATCH_WIDTH-1:0]           disp_ready_o,
    output logic [DISPATCH_WIDTH-1:0][IW-1:0]   disp_rob_idx_o,
    input  logic [WB_WIDTH-1:0]                 wb_valid_i,
    input  logic [WB_WIDTH-1:0][IW-1:0]         wb_rob_idx_i,
    input  logic [WB_WIDTH-1:0]                 wb_mispred_i,
    input  logic [WB_WIDTH-1:0]                 wb_exception_i,
    output logic [COMMIT_WIDTH-1:0]             commit_valid_o,
    output logic [COMMIT_WIDTH-1:0]             commit_rd_wen_o,
    output logic [COMMIT_WIDTH-1:0][AW-1:0]     commit_rd_arch_o,
    output logic [COMMIT_WIDTH-1:0][PW-1:0]     commit_new_prf_o,
    output logic [COMMIT_WIDTH-1:0][PW-1:0]     commit_old_prf_o,
    output logic                                flush_o,
    output logic                                flush_cause_o,
    output logic [IW-1:0]                       flush_rob_idx_o,
    output logic [IW:0]                         count_o
);

    localparam int unsigned LW = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1;
    localparam logic [IW:0] CntOne = 1;

    rob_entry_t mem_q [DEPTH];
    rob_entry_t mem_d [DEPTH];
    logic [IW-1:0] head_q, head_d, tail_q, tail_d;
    logic [IW:0]   count_q, count_d;
    logic [IW:0]   n_alloc, n_commit;

    rob_entry_t [COMMIT_WIDTH-1:0] win;
    logic [DISPATCH_WIDTH-1:0]     disp_alloc;
    logic [LW-1:0]                 flush_lane;

    assign count_o = count_q;

    always_comb begin
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            win[k] = mem_q[head_q + IW'(k)];
            commit_rd_wen_o[k]  = win[k].rd_wen;
            commit_rd_arch_o[k] = AW'(win[k].rd_arch);
            commit_new_prf_o[k] = PW'(win[k].t);
            commit_old_prf_o[k] = PW'(win[k].t_old);
        end
    end

    rob_commit_select #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .LW           (LW)
    ) u_commit_select (
        .win_i          (win),
        .commit_valid_o (commit_valid_o),
        .flush_o        (flush_o),
        .flush_cause_o  (flush_cause_o),
        .flush_lane_o   (flush_lane)
    );

    assign flush_rob_idx_o = head_q + IW'(flush_lane);

    // Readiness depends only on registered occupancy, never on same-cycle commits.
    always_comb begin
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            disp_ready_o[i]   = (int'(DEPTH) - int'(count_q)) > int'(i);
            disp_rob_idx_o[i] = tail_q + IW'(i);
            disp_alloc[i]     = disp_valid_i[i] && disp_ready_o[i] && !flush_o;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        n_alloc  = '0;
        n_commit = '0;
        for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
            if (commit_valid_o[k]) begin
                mem_d[head_q + IW'(k)].valid = 1'b0;
                n_commit = n_commit + CntOne;
            end
        end
        for (int unsigned p = 0; p < WB_WIDTH; p++) begin
            if (wb_valid_i[p] && mem_q[wb_rob_idx_i[p]].valid) begin
                mem_d[wb_rob_idx_i[p]].done    = 1'b1;
                mem_d[wb_rob_idx_i[p]].mispred = mem_d[wb_rob_idx_i[p]].mispred | wb_mispred_i[p];
`ifdef ROB_EXCEPTION_EN
                mem_d[wb_rob_idx_i[p]].exc     = mem_d[wb_rob_idx_i[p]].exc | wb_exception_i[p];
`endif
            end
        end
        for (int unsigned i = 0; i < DISPATCH_WIDTH; i++) begin
            if (disp_alloc[i]) begin
                mem_d[tail_q + IW'(i)] = '{
                    valid:   1'b1,
                    done:    1'b0,
                    mispred: 1'b0,
                    exc:     1'b0,
                    rd_wen:  disp_rd_wen_i[i],
                    rd_arch: ROB_AW'(disp_rd_arch_i[i]),
                    t:       ROB_PW'(disp_new_prf_i[i]),
                    t_old:   ROB_PW'(disp_old_prf_i[i])
                };
                n_alloc = n_alloc + CntOne;
            end
        end
        head_d  = head_q + n_commit[IW-1:0];
        tail_d  = tail_q + n_alloc[IW-1:0];
        count_d = count_q + n_alloc - n_commit;
        if (flush_o) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem_d[e].valid = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

`ifndef ROB_EXCEPTION_EN
    logic unused_exc;
    assign unused_exc = ^wb_exception_i;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer at DEPTH=8; expectations follow ROB_EXCEPTION_EN.
module tb_reorder_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 2;
    localparam int unsigned CW    = 2;
    localparam int unsigned WBW   = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned PW    = 6;
    localparam int unsigned IW    = 3;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [DW-1:0]           disp_valid_i = '0;
    logic [DW-1:0]           disp_rd_wen_i = '0;
    logic [DW-1:0][AW-1:0]   disp_rd_arch_i = '0;
    logic [DW-1:0][PW-1:0]   disp_new_prf_i = '0;
    logic [DW-1:0][PW-1:0]   disp_old_prf_i = '0;
    logic [DW-1:0]           disp_ready_o;
    logic [DW-1:0][IW-1:0]   disp_rob_idx_o;
    logic [WBW-1:0]          wb_valid_i = '0;
    logic [WBW-1:0][IW-1:0]  wb_rob_idx_i = '0;
    logic [WBW-1:0]          wb_mispred_i = '0;
    logic [WBW-1:0]          wb_exception_i = '0;
    logic [CW-1:0]           commit_valid_o;
    logic [CW-1:0]           commit_rd_wen_o;
    logic [CW-1:0][AW-1:0]   commit_rd_arch_o;
    logic [CW-1:0][PW-1:0]   commit_new_prf_o;
    logic [CW-1:0][PW-1:0]   commit_old_prf_o;
    logic                    flush_o;
    logic                    flush_cause_o;
    logic [IW-1:0]           flush_rob_idx_o;
    logic [IW:0]             count_o;

    reorder_buffer #(
        .DEPTH          (DEPTH),
        .DISPATCH_WIDTH (DW),
        .COMMIT_WIDTH   (CW),
        .WB_WIDTH       (WBW),
        .ARCH_REGS      (32),
        .PHYS_REGS      (64)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .disp_valid_i     (disp_valid_i),
        .disp_rd_wen_i    (disp_rd_wen_i),
        .disp_rd_arch_i   (disp_rd_arch_i),
        .disp_new_prf_i   (disp_new_prf_i),
        .disp_old_prf_i   (disp_old_prf_i),
        .disp_ready_o     (disp_ready_o),
        .disp_rob_idx_o   (disp_rob_idx_o),
        .wb_valid_i       (wb_valid_i),
        .wb_rob_idx_i     (wb_rob_idx_i),
        .wb_mispred_i     (wb_mispred_i),
        .wb_exception_i   (wb_exception_i),
        .commit_valid_o   (commit_valid_o),
        .commit_rd_wen_o  (commit_rd_wen_o),
        .commit_rd_arch_o (commit_rd_arch_o),
        .commit_new_prf_o (commit_new_prf_o),
        .commit_old_prf_o (commit_old_prf_o),
        .flush_o          (flush_o),
        .flush_cause_o    (flush_cause_o),
        .flush_rob_idx_o  (flush_rob_idx_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  dv;
        logic [3:0]  wbv;
        logic [11:0] wbi;
        logic [3:0]  mis;
        logic [3:0]  exc;
        int          ecount;
        logic [1:0]  eready;
        logic [1:0]  ecv;
        int          eseq;
        logic        eflush;
        int          efidx;
        logic        ecause;
        int          edidx;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   seq   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] dv, input logic [3:0] wbv, input logic [11:0] wbi,
                       input logic [3:0] mis, input logic [3:0] exc, input int ecount,
                       input logic [1:0] eready, input logic [1:0] ecv, input int eseq,
                       input logic eflush, input int efidx, input logic ecause,
                       input int edidx);
        vec_t v;
        v.dv = dv; v.wbv = wbv; v.wbi = wbi; v.mis = mis; v.exc = exc;
        v.ecount = ecount; v.eready = eready; v.ecv = ecv; v.eseq = eseq;
        v.eflush = eflush; v.efidx = efidx; v.ecause = ecause; v.edidx = edidx;
        vq.push_back(v);
    endtask

    // Lane i carries tags derived from the running sequence number.
    task automatic drive(input logic [1:0] dv, input logic [3:0] wbv, input logic [11:0] wbi,
                         input logic [3:0] mis, input logic [3:0] exc);
        disp_valid_i = dv;
        for (int i = 0; i < int'(DW); i++) begin
            disp_rd_wen_i[i]  = 1'b1;
            disp_rd_arch_i[i] = AW'(seq + i);
            disp_new_prf_i[i] = PW'(seq + i);
            disp_old_prf_i[i] = PW'(seq + i + 32);
        end
        wb_valid_i     = wbv;
        wb_mispred_i   = mis;
        wb_exception_i = exc;
        for (int p = 0; p < int'(WBW); p++) wb_rob_idx_i[p] = wbi[3*p +: 3];
    endtask

    initial begin
        // Vectors: outputs expected just before the edge that applies the inputs.
        add(2'b11, 4'h0, 12'h000, 4'h0, 4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        add(2'b11, 4'h0, 12'h000, 4'h0, 4'h0, 2, 2'b11, 2'b00, 0, 0, 0, 0, 2);
        add(2'b11, 4'h0, 12'h000, 4'h0, 4'h0, 4, 2'b11, 2'b00, 0, 0, 0, 0, 4);
        add(2'b11, 4'h0, 12'h000, 4'h0, 4'h0, 6, 2'b11, 2'b00, 0, 0, 0, 0, 6);
        add(2'b11, 4'h1, {3'd0, 3'd0, 3'd0, 3'd1}, 4'h0, 4'h0, 8, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add(2'b00, 4'h1, {3'd0, 3'd0, 3'd0, 3'd0}, 4'h0, 4'h0, 8, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 8, 2'b00, 2'b11, 0, 0, 0, 0, 0);
        add(2'b00, 4'hf, {3'd5, 3'd4, 3'd3, 3'd2}, 4'h0, 4'h0, 6, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 6, 2'b11, 2'b11, 2, 0, 0, 0, 0);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 4, 2'b11, 2'b11, 4, 0, 0, 0, 0);
        add(2'b11, 4'h0, 12'h000, 4'h0, 4'h0, 2, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        add(2'b00, 4'hf, {3'd1, 3'd0, 3'd7, 3'd6}, 4'h0, 4'h0, 4, 2'b11, 2'b00, 0, 0, 0, 0, 2);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 4, 2'b11, 2'b11, 6, 0, 0, 0, 2);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 2, 2'b11, 2'b11, 8, 0, 0, 0, 2);
        add(2'b11, 4'h0, 12'h000, 4'h0, 4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 2);
        add(2'b11, 4'h3, {3'd0, 3'd0, 3'd3, 3'd2}, 4'h2, 4'h0, 2, 2'b11, 2'b00, 0, 0, 0, 0, 4);
        add(2'b00, 4'h1, {3'd0, 3'd0, 3'd0, 3'd4}, 4'h0, 4'h0, 4, 2'b11, 2'b11, 10, 1, 3, 0, 6);
        add(2'b11, 4'h1, {3'd0, 3'd0, 3'd0, 3'd4}, 4'h0, 4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0);
        add(2'b11, 4'h3, {3'd0, 3'd0, 3'd1, 3'd0}, 4'h0, 4'h0, 2, 2'b11, 2'b00, 0, 0, 0, 0, 2);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 4, 2'b11, 2'b11, 14, 0, 0, 0, 4);
        add(2'b00, 4'h3, {3'd0, 3'd0, 3'd3, 3'd2}, 4'h0, 4'h2, 2, 2'b11, 2'b00, 0, 0, 0, 0, 4);
`ifdef ROB_EXCEPTION_EN
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 2, 2'b11, 2'b01, 16, 0, 0, 0, 4);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 1, 2'b11, 2'b00, 0, 1, 3, 1, 4);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0);
`else
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 2, 2'b11, 2'b11, 16, 0, 0, 0, 4);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 4);
        add(2'b00, 4'h0, 12'h000, 4'h0, 4'h0, 0, 2'b11, 2'b00, 0, 0, 0, 0, 4);
`endif

        // Reset state while rst_n is held low.
        #2;
        check("rst_count", 32'(count_o), 0);
        check("rst_ready", 32'(disp_ready_o), 32'h3);
        check("rst_idx0", 32'(disp_rob_idx_o[0]), 0);
        check("rst_idx1", 32'(disp_rob_idx_o[1]), 1);
        check("rst_cv", 32'(commit_valid_o), 0);
        check("rst_flush", 32'(flush_o), 0);
        check("rst_cause", 32'(flush_cause_o), 0);
        check("rst_fidx", 32'(flush_rob_idx_o), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < vq.size(); v++) begin
            drive(vq[v].dv, vq[v].wbv, vq[v].wbi, vq[v].mis, vq[v].exc);
            #1;
            check($sformatf("v%0d_count", v), 32'(count_o), 32'(vq[v].ecount));
            check($sformatf("v%0d_ready", v), 32'(disp_ready_o), 32'(vq[v].eready));
            check($sformatf("v%0d_cv", v), 32'(commit_valid_o), 32'(vq[v].ecv));
            check($sformatf("v%0d_flush", v), 32'(flush_o), 32'(vq[v].eflush));
            check($sformatf("v%0d_didx0", v), 32'(disp_rob_idx_o[0]), 32'(vq[v].edidx));
            check($sformatf("v%0d_didx1", v), 32'(disp_rob_idx_o[1]), 32'((vq[v].edidx + 1) % 8));
            if (vq[v].ecv[0]) begin
                check($sformatf("v%0d_t0", v), 32'(commit_new_prf_o[0]), 32'(vq[v].eseq));
                check($sformatf("v%0d_told0", v), 32'(commit_old_prf_o[0]),
                      32'(vq[v].eseq + 32));
                check($sformatf("v%0d_arch0", v), 32'(commit_rd_arch_o[0]), 32'(vq[v].eseq));
                check($sformatf("v%0d_wen0", v), 32'(commit_rd_wen_o[0]), 1);
            end
            if (vq[v].ecv[1]) begin
                check($sformatf("v%0d_t1", v), 32'(commit_new_prf_o[1]), 32'(vq[v].eseq + 1));
            end
            if (vq[v].eflush) begin
                check($sformatf("v%0d_fidx", v), 32'(flush_rob_idx_o), 32'(vq[v].efidx));
                check($sformatf("v%0d_cause", v), 32'(flush_cause_o), 32'(vq[v].ecause));
            end
            @(posedge clk);
            if (!vq[v].eflush) begin
                seq += int'(vq[v].dv[0] & vq[v].eready[0]) + int'(vq[v].dv[1] & vq[v].eready[1]);
            end
            @(negedge clk);
        end

        // Build five entries, complete the oldest, then reset mid-operation.
        drive(2'b11, 4'h0, 12'h000, 4'h0, 4'h0);
        @(posedge clk); seq += 2; @(negedge clk);
        drive(2'b11, 4'h0, 12'h000, 4'h0, 4'h0);
        @(posedge clk); seq += 2; @(negedge clk);
        drive(2'b01, 4'hf, {3'd3, 3'd2, 3'd1, 3'd0}, 4'h0, 4'h0);
        @(posedge clk); seq += 1; @(negedge clk);
        drive(2'b00, 4'hf, {3'd7, 3'd6, 3'd5, 3'd4}, 4'h0, 4'h0);
        @(posedge clk); @(negedge clk);
        drive(2'b00, 4'h0, 12'h000, 4'h0, 4'h0);
        #1;
        check("pre_rst_count", 32'(count_o), 5);
        check("pre_rst_cv", 32'(commit_valid_o), 32'h3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count_o), 0);
        check("mid_rst_cv", 32'(commit_valid_o), 0);
        check("mid_rst_flush", 32'(flush_o), 0);
        check("mid_rst_ready", 32'(disp_ready_o), 32'h3);
        check("mid_rst_idx0", 32'(disp_rob_idx_o[0]), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Writebacks to discarded entries must not revive them.
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, 4'hf, {3'd3, 3'd2, 3'd1, 3'd0}, 4'h0, 4'h0);
            #1;
            check($sformatf("post_rst%0d_cv", c), 32'(commit_valid_o), 0);
            check($sformatf("post_rst%0d_flush", c), 32'(flush_o), 0);
            check($sformatf("post_rst%0d_count", c), 32'(count_o), 0);
            @(posedge clk);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
